// File: rtl/trap_arbiter.sv
// trap_arbiter: picks one trap request from the ID/EX/MEM stages by priority.
// The registered trap_status code is held until the trap controller finishes
// its pre-trap handling, then released to TRAP_NONE for at least one cycle.
// Optional feature macro: TRAP_WATCHDOG_EN. When defined, a BUSY watchdog
// aborts a trap that the controller never completes.
module trap_arbiter #(
  parameter int XLEN            = 32,
  parameter int WATCHDOG_CYCLES = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] ID_pc,
  input  logic [XLEN-1:0] EX_pc,
  input  logic [XLEN-1:0] MEM_pc,
  input  logic            ID_ecall,
  input  logic            ID_ebreak,
  input  logic            ID_mret,
  input  logic            ID_fencei,
  input  logic            EX_misaligned_instruction,
  input  logic            MEM_misaligned_load,
  input  logic            MEM_misaligned_store,
  input  logic            trap_done,
  input  logic            pth_done_flush,
  input  logic            debug_mode,
  output logic [2:0]      trap_status,
  output logic            trap_busy,
  output logic [XLEN-1:0] trap_pc,
  output logic            trap_timeout
);

  // Trap codes shared with the trap controller.
  localparam logic [2:0] TRAP_NONE             = 3'd0;
  localparam logic [2:0] TRAP_ECALL            = 3'd1;
  localparam logic [2:0] TRAP_EBREAK           = 3'd2;
  localparam logic [2:0] TRAP_MRET             = 3'd3;
  localparam logic [2:0] TRAP_FENCEI           = 3'd4;
  localparam logic [2:0] TRAP_MISALIGNED_INSTR = 3'd5;
  localparam logic [2:0] TRAP_MISALIGNED_LOAD  = 3'd6;
  localparam logic [2:0] TRAP_MISALIGNED_STORE = 3'd7;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    FLUSH,
    PULSE
  } state_t;

  state_t          state;
  logic            sel_valid;
  logic [2:0]      sel_code;
  logic [XLEN-1:0] sel_pc;
  logic            wd_expire;

  // Priority pick among the raw requests; in debug mode only MRET may win.
  always_comb begin
    sel_valid = 1'b1;
    sel_code  = TRAP_NONE;
    sel_pc    = ID_pc;
    if (debug_mode) begin
      if (ID_mret) begin
        sel_code = TRAP_MRET;
      end else begin
        sel_valid = 1'b0;
      end
    end else if (MEM_misaligned_store) begin
      sel_code = TRAP_MISALIGNED_STORE;
      sel_pc   = MEM_pc;
    end else if (MEM_misaligned_load) begin
      sel_code = TRAP_MISALIGNED_LOAD;
      sel_pc   = MEM_pc;
    end else if (EX_misaligned_instruction) begin
      sel_code = TRAP_MISALIGNED_INSTR;
      sel_pc   = EX_pc;
    end else if (ID_ebreak) begin
      sel_code = TRAP_EBREAK;
    end else if (ID_ecall) begin
      sel_code = TRAP_ECALL;
    end else if (ID_mret) begin
      sel_code = TRAP_MRET;
    end else if (ID_fencei) begin
      sel_code = TRAP_FENCEI;
    end else begin
      sel_valid = 1'b0;
    end
  end

`ifdef TRAP_WATCHDOG_EN
  localparam int WD_W = $clog2(WATCHDOG_CYCLES) + 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WATCHDOG_CYCLES - 1);

  logic [WD_W-1:0] wd_count;
  logic            timeout_q;

  assign wd_expire    = (wd_count == WD_LAST);
  assign trap_timeout = timeout_q;

  // Count BUSY cycles; the count sits at zero whenever a trap is not pending.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_count  <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= (state == BUSY) && !trap_done && wd_expire;
      if (state == BUSY) begin
        wd_count <= wd_count + 1'b1;
      end else begin
        wd_count <= '0;
      end
    end
  end
`else
  logic unused_wd_cfg;

  assign unused_wd_cfg = ^WATCHDOG_CYCLES;
  assign wd_expire     = 1'b0;
  assign trap_timeout  = 1'b0;
`endif

  // Ownership FSM: capture in IDLE, hold through handling, release to NONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      trap_status <= TRAP_NONE;
      trap_busy   <= 1'b0;
      trap_pc     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (sel_valid) begin
            trap_status <= sel_code;
            trap_pc     <= sel_pc;
            trap_busy   <= 1'b1;
            state       <= (sel_code == TRAP_FENCEI) ? PULSE : BUSY;
          end
        end
        BUSY: begin
          if (trap_done && pth_done_flush) begin
            state <= FLUSH;
          end else if (trap_done || wd_expire) begin
            state       <= IDLE;
            trap_status <= TRAP_NONE;
            trap_busy   <= 1'b0;
            trap_pc     <= '0;
          end
        end
        FLUSH, PULSE: begin
          state       <= IDLE;
          trap_status <= TRAP_NONE;
          trap_busy   <= 1'b0;
          trap_pc     <= '0;
        end
        default: begin
          state       <= IDLE;
          trap_status <= TRAP_NONE;
          trap_busy   <= 1'b0;
          trap_pc     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trap_arbiter.sv
// tb_trap_arbiter: directed scenarios plus randomized traffic for
// trap_arbiter, checked every cycle against a transaction-level model.
// Build with TRAP_WATCHDOG_EN defined to exercise the watchdog (8 cycles).
module tb_trap_arbiter;

  localparam int XLEN = 32;
`ifdef TRAP_WATCHDOG_EN
  localparam int WD = 8;
`else
  localparam int WD = 64;
`endif

  localparam logic [2:0] TRAP_NONE             = 3'd0;
  localparam logic [2:0] TRAP_ECALL            = 3'd1;
  localparam logic [2:0] TRAP_EBREAK           = 3'd2;
  localparam logic [2:0] TRAP_MRET             = 3'd3;
  localparam logic [2:0] TRAP_FENCEI           = 3'd4;
  localparam logic [2:0] TRAP_MISALIGNED_INSTR = 3'd5;
  localparam logic [2:0] TRAP_MISALIGNED_LOAD  = 3'd6;
  localparam logic [2:0] TRAP_MISALIGNED_STORE = 3'd7;

  // Request vector in priority order, highest first:
  // 0 store, 1 load, 2 ex misaligned, 3 ebreak, 4 ecall, 5 mret, 6 fencei.
  localparam logic [6:0] S_STORE  = 7'b0000001;
  localparam logic [6:0] S_LOAD   = 7'b0000010;
  localparam logic [6:0] S_INSTR  = 7'b0000100;
  localparam logic [6:0] S_EBREAK = 7'b0001000;
  localparam logic [6:0] S_ECALL  = 7'b0010000;
  localparam logic [6:0] S_MRET   = 7'b0100000;
  localparam logic [6:0] S_FENCEI = 7'b1000000;

  logic            clk;
  logic            reset;
  logic [6:0]      src;
  logic [XLEN-1:0] id_pc, ex_pc, mem_pc;
  logic            done, flush, dbg;
  logic [2:0]      trap_status;
  logic            trap_busy;
  logic [XLEN-1:0] trap_pc;
  logic            trap_timeout;

  int n_compared;
  int n_mismatched;

  // Reference model: who owns a trap, what it shows, and how it will end.
  logic            m_owned;
  logic [2:0]      m_code;
  logic [XLEN-1:0] m_pc;
  logic            m_one_shot;
  int              m_wd;
  logic            m_timeout;

  trap_arbiter #(.XLEN(XLEN), .WATCHDOG_CYCLES(WD)) dut (
    .clk                       (clk),
    .reset                     (reset),
    .ID_pc                     (id_pc),
    .EX_pc                     (ex_pc),
    .MEM_pc                    (mem_pc),
    .ID_ecall                  (src[4]),
    .ID_ebreak                 (src[3]),
    .ID_mret                   (src[5]),
    .ID_fencei                 (src[6]),
    .EX_misaligned_instruction (src[2]),
    .MEM_misaligned_load       (src[1]),
    .MEM_misaligned_store      (src[0]),
    .trap_done                 (done),
    .pth_done_flush            (flush),
    .debug_mode                (dbg),
    .trap_status               (trap_status),
    .trap_busy                 (trap_busy),
    .trap_pc                   (trap_pc),
    .trap_timeout              (trap_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [6:0] s, input logic d, input logic f, input logic g);
    src    = s;
    done   = d;
    flush  = f;
    dbg    = g;
    id_pc  = XLEN'($urandom) & ~XLEN'(3);
    ex_pc  = XLEN'($urandom) & ~XLEN'(3);
    mem_pc = XLEN'($urandom) & ~XLEN'(3);
  endtask

  function automatic logic [2:0] codeOf(input int i);
    case (i)
      0: return TRAP_MISALIGNED_STORE;
      1: return TRAP_MISALIGNED_LOAD;
      2: return TRAP_MISALIGNED_INSTR;
      3: return TRAP_EBREAK;
      4: return TRAP_ECALL;
      5: return TRAP_MRET;
      default: return TRAP_FENCEI;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] pcOf(input int i);
    if (i < 2) return mem_pc;
    if (i == 2) return ex_pc;
    return id_pc;
  endfunction

  task automatic modelReset();
    m_owned    = 1'b0;
    m_code     = TRAP_NONE;
    m_pc       = '0;
    m_one_shot = 1'b0;
    m_wd       = 0;
    m_timeout  = 1'b0;
  endtask

  task automatic modelRelease();
    m_owned    = 1'b0;
    m_code     = TRAP_NONE;
    m_pc       = '0;
    m_one_shot = 1'b0;
  endtask

  // One clock edge of the reference behaviour, using the inputs now applied.
  task automatic modelStep();
    logic [6:0] req;
    m_timeout = 1'b0;
    if (!m_owned) begin
      req = dbg ? (src & S_MRET) : src;
      for (int i = 0; i < 7; i++) begin
        if (req[i]) begin
          m_owned    = 1'b1;
          m_code     = codeOf(i);
          m_pc       = pcOf(i);
          m_one_shot = (i == 6);
          m_wd       = 0;
          break;
        end
      end
    end else if (m_one_shot) begin
      modelRelease();
    end else if (done && flush) begin
      m_one_shot = 1'b1;
    end else if (done) begin
      modelRelease();
    end else begin
`ifdef TRAP_WATCHDOG_EN
      if (m_wd == WD - 1) begin
        modelRelease();
        m_timeout = 1'b1;
      end else begin
        m_wd++;
      end
`endif
    end
  endtask

  task automatic compareAll();
    checkOutput("status", 64'(trap_status), 64'(m_code));
    checkOutput("busy", 64'(trap_busy), 64'(m_owned));
    checkOutput("pc", 64'(trap_pc), 64'(m_pc));
    checkOutput("timeout", 64'(trap_timeout), 64'(m_timeout));
  endtask

  task automatic tick();
    @(posedge clk);
    modelStep();
    @(negedge clk);
    compareAll();
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    reset = 1'b1;
    applyStimulus('0, 1'b1, 1'b0, 1'b0);
    modelReset();
    #7;
    compareAll();
    @(negedge clk);
    reset = 1'b0;

    // Misaligned load beats a simultaneous ecall.
    applyStimulus(S_LOAD | S_ECALL, 1'b1, 1'b0, 1'b0);
    mem_pc = 32'h100;
    tick();
    checkOutput("load_code", 64'(trap_status), 64'(TRAP_MISALIGNED_LOAD));
    checkOutput("load_pc", 64'(trap_pc), 64'h100);
    applyStimulus('0, 1'b1, 1'b1, 1'b0);
    tick();
    tick();
    applyStimulus('0, 1'b1, 1'b0, 1'b0);
    tick();

    // Ebreak held for three cycles, then released.
    applyStimulus(S_EBREAK, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus('0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("ebreak_hold", 64'(trap_status), 64'(TRAP_EBREAK));
    applyStimulus('0, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("ebreak_rel", 64'(trap_status), 64'(TRAP_NONE));

    // Debug mode: ecall ignored, mret accepted.
    applyStimulus(S_ECALL, 1'b1, 1'b0, 1'b1);
    tick();
    checkOutput("dbg_ecall", 64'(trap_busy), 64'd0);
    applyStimulus(S_MRET | S_ECALL, 1'b1, 1'b0, 1'b1);
    tick();
    checkOutput("dbg_mret", 64'(trap_status), 64'(TRAP_MRET));
    applyStimulus('0, 1'b1, 1'b0, 1'b0);
    tick();

    // Fence.i: exactly one cycle of TRAP_FENCEI.
    applyStimulus(S_FENCEI, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("fencei_on", 64'(trap_status), 64'(TRAP_FENCEI));
    applyStimulus(S_FENCEI, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("fencei_off", 64'(trap_status), 64'(TRAP_NONE));
    applyStimulus('0, 1'b1, 1'b0, 1'b0);
    tick();

    // Misaligned instruction through a full handling sequence.
    applyStimulus(S_INSTR, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(S_STORE, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    applyStimulus('0, 1'b1, 1'b1, 1'b0);
    tick();
    checkOutput("flush_hold", 64'(trap_status), 64'(TRAP_MISALIGNED_INSTR));
    tick();
    checkOutput("flush_rel", 64'(trap_status), 64'(TRAP_NONE));
    applyStimulus('0, 1'b1, 1'b0, 1'b0);
    tick();

    // Asynchronous reset in the middle of a trap.
    applyStimulus(S_ECALL, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus('0, 1'b0, 1'b0, 1'b0);
    tick();
    #2;
    reset = 1'b1;
    #1;
    modelReset();
    checkOutput("rst_status", 64'(trap_status), 64'(TRAP_NONE));
    checkOutput("rst_busy", 64'(trap_busy), 64'd0);
    checkOutput("rst_pc", 64'(trap_pc), 64'd0);
    @(negedge clk);
    reset = 1'b0;

`ifdef TRAP_WATCHDOG_EN
    // Watchdog: controller never finishes.
    applyStimulus(S_EBREAK, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus('0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < WD - 1; i++) tick();
    checkOutput("wd_hold", 64'(trap_status), 64'(TRAP_EBREAK));
    tick();
    checkOutput("wd_pulse", 64'(trap_timeout), 64'd1);
    checkOutput("wd_status", 64'(trap_status), 64'(TRAP_NONE));
    tick();
    checkOutput("wd_pulse_end", 64'(trap_timeout), 64'd0);
`endif

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      logic [6:0] s;
      s = '0;
      for (int b = 0; b < 7; b++) s[b] = ($urandom_range(0, 5) == 0);
      applyStimulus(s, ($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1,
                    ($urandom_range(0, 7) == 0));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/trap_arbiter.md
# trap_arbiter

Upstream companion of the trap controller in the RV32I pipeline. Collects trap requests from the ID, EX and MEM stages and selects one by priority. Drives a registered `trap_status` code into the trap controller and holds it stable until that controller's pre-trap handling FSM has finished. Releases it exactly when the controller returns to idle, so a trap is never re-triggered or dropped mid-handling.

## Interface
- `XLEN`, default 32: data/PC width.
- `WATCHDOG_CYCLES`, default 64: watchdog limit in cycles. Used only when `TRAP_WATCHDOG_EN` is defined.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `ID_pc`, `EX_pc`, `MEM_pc`  in  XLEN  PCs of the instructions in the ID, EX and MEM stages.
- `ID_ecall`, `ID_ebreak`, `ID_mret`, `ID_fencei`  in  1  decoded system instructions in ID.
- `EX_misaligned_instruction`  in  1  branch/jump target in EX not 4-byte aligned.
- `MEM_misaligned_load`, `MEM_misaligned_store`  in  1  misaligned data access in MEM.
- `trap_done`  in  1  from trap controller; 0 = pre-trap handling in progress.
- `pth_done_flush`  in  1  from trap controller; final flush/redirect cycles.
- `debug_mode`  in  1  from trap controller.
- `trap_status`  out  3  `trap.vh` code presented to the trap controller.
- `trap_busy`  out  1  arbiter owns a trap (state ≠ IDLE).
- `trap_pc`  out  XLEN  PC of the selected trapping instruction.
- `trap_timeout`  out  1  one-cycle watchdog abort pulse.

## Operation
- States: IDLE, BUSY, FLUSH, PULSE.
- **Priority**, highest first, applied to sources sampled in IDLE:
  1. MEM_misaligned_store (wins if both MEM flags are set).
  2. MEM_misaligned_load.
  3. EX_misaligned_instruction.
  4. ID_ebreak.
  5. ID_ecall.
  6. ID_mret.
  7. ID_fencei.
- **trap_pc capture**: taken from the stage of the winning source (MEM_pc, EX_pc or ID_pc).
- **debug_mode=1**: only ID_mret is accepted; all other requests are ignored. They are not queued.
- **IDLE → BUSY**: a non-FENCEI source wins. `trap_status`, `trap_pc` and `trap_busy` are registered at the same edge.
- **IDLE → PULSE**: ID_fencei wins. PULSE drives `TRAP_FENCEI` for exactly one cycle, then returns to IDLE with `TRAP_NONE`.
- **In BUSY**, evaluated each cycle, outputs held:
  - `trap_done`=0: stay in BUSY.
  - `trap_done`=1 and `pth_done_flush`=0: go to IDLE and drive `TRAP_NONE`. This is the EBREAK and MRET completion.
  - `trap_done`=1 and `pth_done_flush`=1: go to FLUSH.
- **FLUSH**: holds the status for one more cycle, matching the controller's final redirect cycle. Next edge → IDLE with `TRAP_NONE`.
- **Inputs ignored while not IDLE**: new source requests are ignored in BUSY, FLUSH and PULSE.
- **Gap between traps**: every release leaves at least one `TRAP_NONE` cycle before the next capture.
- **Reset**: all outputs go to 0 / `TRAP_NONE` and the state goes to IDLE, immediately, including mid-trap.

## Timing
- Capture latency: a source asserted in cycle N appears on `trap_status` in cycle N+1.
- All outputs are registered; no combinational path from inputs to outputs.
- EBREAK: status is held from the capture edge until the edge after `trap_done` rises.
- MRET: same rule as EBREAK.
- Misaligned and ECALL traps: status is held through both `pth_done_flush` cycles, then drops.
- FENCEI: status is high for exactly 1 cycle; `trap_busy` is high for that cycle.
- Release is simultaneous with a new request: the release wins; the request is dropped.

## Configuration
- Macro: `TRAP_WATCHDOG_EN`.
- **Defined**:
  - An XLEN-independent counter (width clog2(WATCHDOG_CYCLES)+1) clears on entry to BUSY and increments each BUSY cycle.
  - At count == WATCHDOG_CYCLES-1 with no release, the next edge goes to IDLE, drives `TRAP_NONE` and pulses `trap_timeout` for 1 cycle.
- **Undefined**: no counter; `trap_timeout` is constant 0; BUSY waits indefinitely.

## Test plan
- MEM_misaligned_load and ID_ecall in the same cycle, MEM_pc=0x100 → `TRAP_MISALIGNED_LOAD` next cycle, `trap_pc`=0x100; ecall is ignored.
- ID_ebreak; `trap_done` goes 0 for 2 cycles then 1 → status is held for 3 cycles, then `TRAP_NONE`. Then set `debug_mode`=1 and assert ID_ecall → no capture. Then assert ID_mret → `TRAP_MRET` captured.
- ID_fencei with no other sources → exactly one cycle of `TRAP_FENCEI`, then `TRAP_NONE`.
- EX_misaligned_instruction, controller runs the full sequence ending with 2 cycles of `trap_done`=1 and `pth_done_flush`=1 → status drops on the edge after the second flush cycle.
- Reset asserted while in BUSY → `trap_status`=`TRAP_NONE`, `trap_busy`=0 and `trap_pc`=0 asynchronously, before the next clock edge.
- With `TRAP_WATCHDOG_EN` and `WATCHDOG_CYCLES`=8, `trap_done` held at 0 → after 8 BUSY cycles, `trap_timeout` pulses once and status goes to `TRAP_NONE`.
